// File: rtl/booth_mult_ctrl_if.sv
// Handshake and result bundle between the operand-capture logic, the Booth
// multiplier controller and the result/display path.
interface booth_mult_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    logic                    start;
    logic                    hold;
    logic signed [WIDTH-1:0] multiplicand;
    logic signed [WIDTH-1:0] multiplier;
    logic                    busy;
    logic                    done;
    logic [2*WIDTH-1:0]      product;
    logic [CNT_W-1:0]        step;

    modport master (
        output start, hold, multiplicand, multiplier,
        input  busy, done, product, step
    );

    modport slave (
        input  start, hold, multiplicand, multiplier,
        output busy, done, product, step
    );
endinterface

// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth multiplier: one step per non-held RUN cycle, WIDTH
// steps per operation, registered signed product with a one-cycle done pulse.
module booth_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    booth_mult_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    // A and M carry one extra sign bit so that A +/- M never overflows,
    // even with a -2^(WIDTH-1) operand.
    logic [WIDTH:0]       acc;
    logic [WIDTH:0]       mcand;
    logic [WIDTH-1:0]     q_reg;
    logic                 q_1;
    logic [CNT_W-1:0]     step_cnt;
    logic [2*WIDTH-1:0]   product_reg;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       acc_sh;
    logic [WIDTH-1:0]     q_sh;
    logic                 q1_sh;
    logic                 last_step;
    logic                 busy;
    logic                 done;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        sum        = acc;

        unique case ({q_reg[0], q_1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase

        acc_sh    = {sum[WIDTH], sum[WIDTH:1]};
        q_sh      = {sum[0], q_reg[WIDTH-1:1]};
        q1_sh     = q_reg[0];
        last_step = (step_cnt == CNT_W'(WIDTH - 1));

        unique case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (!bus.hold && last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        busy = (state != IDLE);
        done = (state == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc         <= '0;
            mcand       <= '0;
            q_reg       <= '0;
            q_1         <= 1'b0;
            step_cnt    <= '0;
            product_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc      <= '0;
                        mcand    <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
                        q_reg    <= bus.multiplier;
                        q_1      <= 1'b0;
                        step_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!bus.hold) begin
                        acc   <= acc_sh;
                        q_reg <= q_sh;
                        q_1   <= q1_sh;
                        // Product is taken from the post-shift values of the final step.
                        if (last_step) product_reg <= {acc_sh[WIDTH-1:0], q_sh};
                        else           step_cnt    <= step_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_reg;
    assign bus.step    = step_cnt;
endmodule
